// File: rtl/edge_evt_pkg.sv
// Shared types, constants and the round-robin pick used by the edge event arbiter.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DEBOUNCE_CYC = 16;
  localparam int MAX_CH               = 16;
  localparam int MAX_ID_W             = 4;

  // First set bit of mask scanning upward from last+1, wrapping at n_ch.
  function automatic logic [MAX_ID_W-1:0] rr_next(
    input logic [MAX_CH-1:0]   mask,
    input logic [MAX_ID_W-1:0] last,
    input int unsigned         n_ch
  );
    logic [MAX_ID_W-1:0] sel;
    logic                found;
    logic [MAX_ID_W:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      idx = {1'b0, last} + (MAX_ID_W + 1)'(k);
      if (idx >= (MAX_ID_W + 1)'(n_ch)) begin
        idx = idx - (MAX_ID_W + 1)'(n_ch);
      end
      if (!found && (k <= n_ch) && mask[idx[MAX_ID_W-1:0]]) begin
        sel   = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/edge_debounce_ch.sv
// One input lane: 2-flop synchroniser, debounce counter, stable level and a
// one-cycle falling-edge pulse (fall_o) the cycle after stable drops to 0.
module edge_debounce_ch
  import edge_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic fall_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never land.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign fall_o = stable_dly_q & ~stable_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Debounced falling-edge capture on N_CH active-low lines, latched as pending
// events and offered one at a time, round-robin, over a valid/ready handshake.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int ID_W         = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] signal_in,
  input  logic [N_CH-1:0] ch_enable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun,
  input  logic [N_CH-1:0] clr_overrun
);

  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] edge_set;
  logic [N_CH-1:0] grant_clr;
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] overrun_q;
  logic [N_CH-1:0] overrun_d;
  logic            accept;

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [ID_W-1:0] evt_id_q;
  logic [ID_W-1:0] evt_id_d;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] last_grant_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw_i (signal_in[g]),
      .fall_o(fall[g])
    );
  end

  assign accept   = (state_q == OFFER) && evt_ready;
  assign edge_set = fall & ch_enable;

  always_comb begin
    grant_clr = '0;
    if (accept) begin
      grant_clr[evt_id_q] = 1'b1;
    end
  end

  // A fresh edge beats the grant clear; only an edge on a still-pending
  // channel counts as an overrun.
  always_comb begin
    pending_d = (pending_q & ~grant_clr) | edge_set;
    overrun_d = (overrun_q & ~clr_overrun) | (edge_set & pending_q & ~grant_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_CH - 1);
    end else begin
      state_q      <= state_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          evt_id_d = ID_W'(rr_next(MAX_CH'(pending_q), MAX_ID_W'(last_grant_q), N_CH));
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          last_grant_d = evt_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state_q == OFFER);
  end

  assign evt_id  = evt_id_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench with a cycle-level behavioural model compared every cycle.
module tb_edge_event_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] signal_in;
  logic [N-1:0] ch_enable;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic [N-1:0] clr_overrun;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  edge_event_arbiter #(.N_CH(N), .DEBOUNCE_CYC(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .ch_enable  (ch_enable),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .pending    (pending),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a sample of signal_in that has disagreed with the stable level for
  // D consecutive edges flips it; a 1->0 flip at edge k lands in pending at k+3.
  int           cyc;
  logic [N-1:0] m_stable, m_pend, m_ovr, m_old, m_set, m_clr;
  int           m_run[N];
  int           m_due[N];
  logic         m_offer, m_acc;
  int           m_id, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_stable = '1; m_pend = '0; m_ovr = '0;
      m_offer = 1'b0; m_id = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_due[i] = -1; end
    end else begin
      cyc++;
      m_acc = m_offer && evt_ready;
      m_old = m_pend; m_set = '0; m_clr = '0;
      if (m_acc) m_clr[m_id] = 1'b1;
      for (int i = 0; i < N; i++)
        if (m_due[i] == cyc && ch_enable[i]) m_set[i] = 1'b1;
      m_ovr  = (m_ovr & ~clr_overrun) | (m_set & m_old & ~m_clr);
      m_pend = (m_old & ~m_clr) | m_set;
      if (m_offer) begin
        if (m_acc) begin m_offer = 1'b0; m_last = m_id; end
      end else if (m_old != '0) begin
        for (int k = N; k >= 1; k--)
          if (m_old[(m_last + k) % N]) m_id = (m_last + k) % N;
        m_offer = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (signal_in[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = signal_in[i];
            m_run[i]    = 0;
            if (!signal_in[i]) m_due[i] = cyc + 3;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && cmp_en) begin
      check("model_valid", evt_valid, m_offer);
      if (m_offer) check("model_id", evt_id, m_id);
      check("model_pending", pending, m_pend);
      check("model_overrun", overrun, m_ovr);
    end
  end

  int acc_cnt = 0;
  int acc_ids[$];
  int acc_cyc[$];

  always @(negedge clk) begin
    #2;
    if (!rst && evt_valid && evt_ready) begin
      acc_cnt++;
      acc_ids.push_back(evt_id);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #2;
      if (evt_valid) begin n = i; return; end
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic serve_round(input string tag);
    int b;
    b = acc_ids.size();
    @(negedge clk) signal_in = 4'b0100;
    idle(25);
    check({tag, "_count"}, acc_ids.size() - b, 3);
    if (acc_ids.size() - b == 3) begin
      check({tag, "_first"},  acc_ids[b],     0);
      check({tag, "_second"}, acc_ids[b + 1], 1);
      check({tag, "_third"},  acc_ids[b + 2], 3);
      check({tag, "_gap1"},   acc_cyc[b + 1] - acc_cyc[b],     2);
      check({tag, "_gap2"},   acc_cyc[b + 2] - acc_cyc[b + 1], 2);
    end
    signal_in = '1;
    idle(15);
  endtask

  initial begin
    int n, base;
    rst = 1'b1; signal_in = '1; ch_enable = '1; evt_ready = 1'b1; clr_overrun = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk) rst = 1'b0; cmp_en = 1'b1;
    idle(3);

    // Channels 0, 1, 3 together, twice: both rounds start at 0.
    serve_round("rr_round1");
    serve_round("rr_round2");

    // Single edge latency.
    base = acc_cnt;
    @(negedge clk) signal_in[2] = 1'b0;
    wait_valid("single", n);
    check("single_latency", n, D + 4);
    check("single_id", evt_id, 2);
    @(negedge clk); #2;
    check("single_one_cycle", evt_valid, 0);
    check("single_pending_clear", pending, 0);
    signal_in[2] = 1'b1;
    idle(15);
    check("single_release_no_evt", acc_cnt - base, 1);

    // Three-cycle glitch is rejected.
    base = acc_cnt;
    @(negedge clk) signal_in[1] = 1'b0;
    idle(3);
    signal_in[1] = 1'b1;
    idle(15);
    check("glitch_no_evt", acc_cnt - base, 0);
    #2;
    check("glitch_pending", pending, 0);

    // Backpressure and overrun.
    @(negedge clk) evt_ready = 1'b0; signal_in[0] = 1'b0;
    wait_valid("bp", n);
    check("bp_id", evt_id, 0);
    signal_in[0] = 1'b1;
    idle(12);
    signal_in[0] = 1'b0;
    idle(12);
    #2;
    check("bp_valid_held", evt_valid, 1);
    check("bp_id_held", evt_id, 0);
    check("bp_overrun", overrun[0], 1);
    check("bp_pending", pending[0], 1);
    base = acc_cnt;
    @(negedge clk) evt_ready = 1'b1;
    idle(10);
    check("bp_one_event", acc_cnt - base, 1);
    #2;
    check("bp_pending_clear", pending, 0);
    @(negedge clk) clr_overrun = 4'b0001;
    @(negedge clk) clr_overrun = '0;
    #2;
    check("bp_overrun_cleared", overrun, 0);
    signal_in[0] = 1'b1;
    idle(12);

    // Disabled channel captures nothing.
    base = acc_cnt;
    @(negedge clk) ch_enable[3] = 1'b0; signal_in[3] = 1'b0;
    idle(15);
    #2;
    check("en_pending", pending, 0);
    check("en_no_evt", acc_cnt - base, 0);

    // Reset in the middle of an offer with an overrun pending.
    @(negedge clk) evt_ready = 1'b0; signal_in[0] = 1'b0;
    wait_valid("rst_offer", n);
    signal_in[0] = 1'b1;
    idle(12);
    signal_in[0] = 1'b0;
    idle(12);
    #2;
    check("pre_rst_overrun", overrun[0], 1);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", evt_valid, 0);
    check("async_rst_pending", pending, 0);
    check("async_rst_overrun", overrun, 0);
    signal_in = '1; ch_enable = '1; evt_ready = 1'b1;
    idle(2);
    @(negedge clk) rst = 1'b0;
    base = acc_cnt;
    idle(20);
    check("post_rst_no_evt", acc_cnt - base, 0);
    #2;
    check("post_rst_valid", evt_valid, 0);
    check("post_rst_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
